rsa_job_ctrl: RTL
=================

Name: rsa_job_ctrl

Overview:
Host-side initiator that drives one rsa_unit exponentiation core and sits between a valid/ready job stream and that core. Per job it:
- latches P/E/M,
- computes the Montgomery constant Const = 2^(2*(WIDTH+2)) mod M,
- pulses the core's reset, enables it and waits for eoc,
- captures C and returns it on a valid/ready result port.

It also rejects illegal moduli and enforces a cycle timeout.

Parameters:
WIDTH, 8, operand width (matches rsa_unit WIDTH)
CYCLE_LIMIT, 4096, max RUN cycles before timeout error
CLR_CYCLES, 2, cycles unit_rstb held low before each job

Ports:
clk  in  1  clock
rst  in  1  synchronous active-high reset
in_valid  in  1  job offered
in_ready  out  1  block can accept job
in_p  in  WIDTH  message/base
in_e  in  WIDTH  exponent
in_m  in  WIDTH  modulus
out_valid  out  1  result available
out_ready  in  1  host accepts result
out_c  out  WIDTH  result P^E mod M
out_err  out  1  job failed (bad modulus or timeout)
unit_en  out  1  to rsa_unit en
unit_rstb  out  1  to rsa_unit rstb (active low)
unit_p, unit_e, unit_m, unit_const  out  WIDTH each  operands to rsa_unit
unit_c  in  WIDTH  rsa_unit C
unit_eoc  in  1  rsa_unit eoc

Behaviour:
- Reset (rst=1 at clk edge), takes effect regardless of state:
  - Go to IDLE.
  - in_ready=1, out_valid=0, out_c=0, out_err=0.
  - unit_en=0, unit_rstb=0.
  - unit_p/e/m/const=0.
  - Timeout counter=0.
- IDLE:
  - in_ready=1, unit_rstb=0, unit_en=0.
  - On in_valid&in_ready, latch in_p/e/m into unit_p/e/m; in_ready drops next cycle.
  - If in_m is even or in_m<3, go to RESP with out_c=0, out_err=1. No core activity.
  - Otherwise go to CONST.
- CONST:
  - Accumulator x (WIDTH+1 bits) starts at 1.
  - Each cycle: x = 2x; if x>=M then x = x-M.
  - Runs exactly 2*(WIDTH+2) cycles.
  - Then unit_const = x[WIDTH-1:0]; go to CLEAR.
- CLEAR:
  - unit_rstb=0, unit_en=0 for CLR_CYCLES cycles; operands held stable.
  - Then go to RUN.
- RUN:
  - unit_rstb=1, unit_en=1; timeout counter increments each cycle.
  - First cycle with unit_eoc=1: go to CAPTURE. unit_en stays 1, because the core's result register loads on eoc and is valid one cycle later.
  - Counter reaching CYCLE_LIMIT with no eoc: go to RESP with out_err=1, out_c=0.
  - eoc and limit on the same cycle: eoc wins.
- CAPTURE (1 cycle):
  - out_c = unit_c, out_err=0.
  - unit_en=0, unit_rstb=0.
  - Go to RESP.
- RESP:
  - out_valid=1; out_c/out_err held stable until out_valid&out_ready.
  - Then out_valid=0 next cycle, return to IDLE.
  - No new job accepted while a result is pending (single outstanding job).
- Operand stability: unit_p/e/m/const change only in IDLE accept cycle and at CONST end. They never change during CLEAR/RUN/CAPTURE.
- No check that P<M. The result is then whatever the core produces, passed unmodified.
- Latency from accept to out_valid with a good job: 1 + 2*(WIDTH+2) + CLR_CYCLES + T_core + 1 cycles.
- unit_eoc high while in IDLE/CONST/CLEAR is ignored.

Decomposition:
- Package rsa_pkg:
  - state enum typedef (IDLE, CONST, CLEAR, RUN, CAPTURE, RESP);
  - localparam functions for EXT_W=WIDTH+2 and CONST_ITERS=2*EXT_W.
- One sub-module, rsa_const_gen: start/done handshake plus the modular doubling loop. Reusable by any future key-setup block.

Test Plan:
- WIDTH=8, job P=88, E=7, M=187 with real rsa_unit -> unit_const=67 (2^20 mod 187) at CONST end; out_valid with out_c=11, out_err=0.
- Job P=5, E=1, M=187 -> out_c=5. Back-to-back second job P=2, E=10, M=187 accepted only after first result handshake -> out_c=89 (1024 mod 187).
- Job M=186 (even), then M=1 -> each gives out_valid within 2 cycles of accept, out_err=1, out_c=0, unit_en never asserted.
- Stub core holding unit_eoc=0, CYCLE_LIMIT=64 -> unit_en high exactly 64 cycles, then out_err=1, out_c=0, unit_en=0.
- Hold out_ready=0 for 10 cycles after out_valid -> out_valid/out_c/out_err stable, in_ready=0, in_valid pulses ignored. out_ready=1 -> handshake, IDLE next cycle.
- Assert rst for 1 cycle mid-RUN -> next cycle unit_en=0, unit_rstb=0, in_ready=1, out_valid=0. A following job completes correctly.

Source files
------------

// File: rtl/rsa_pkg.sv
// rsa_pkg: shared FSM state type and Montgomery constant sizing helpers for the RSA job controller.
package rsa_pkg;
  typedef enum logic [2:0] {IDLE, CONST, CLEAR, RUN, CAPTURE, RESP} state_e;
  function automatic int ext_w(int w);
    return w + 2;
  endfunction
  function automatic int const_iters(int w);
    return 2 * ext_w(w);
  endfunction
endpackage

// File: rtl/rsa_const_gen.sv
// rsa_const_gen: computes 2^(2*(WIDTH+2)) mod m by repeated modular doubling.
// Ports: clk, rst (sync, active high); start loads x=1; m is the odd modulus, m>=3, held stable while busy;
// done pulses on the last iteration with the constant presented combinationally on value.
module rsa_const_gen
  import rsa_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] m,
  output logic             done,
  output logic [WIDTH-1:0] value
);
  localparam int ITERS = const_iters(WIDTH);
  localparam int CW = $clog2(ITERS + 1);
  logic             busy_q, busy_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [WIDTH:0]   x_q, x_d, dbl;
  // x < m < 2^WIDTH, so the doubled value always fits in WIDTH+1 bits
  always_comb begin
    dbl = {x_q[WIDTH-1:0], 1'b0};
    done = busy_q && cnt_q == CW'(ITERS - 1);
    x_d = start ? (WIDTH+1)'(1) : busy_q ? (dbl >= {1'b0, m} ? dbl - {1'b0, m} : dbl) : x_q;
    cnt_d = start ? '0 : busy_q ? cnt_q + CW'(1) : cnt_q;
    busy_d = start | (busy_q & ~done);
    value = x_d[WIDTH-1:0];
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      busy_q <= 1'b0;
      cnt_q <= '0;
      x_q <= '0;
    end else begin
      busy_q <= busy_d;
      cnt_q <= cnt_d;
      x_q <= x_d;
    end
  end
endmodule

// File: rtl/rsa_job_ctrl.sv
// rsa_job_ctrl: valid/ready job front end that sequences one rsa_unit exponentiation core per job.
// Ports: clk, rst (sync, active high); in_valid/in_ready/in_p/in_e/in_m job stream;
// out_valid/out_ready/out_c/out_err result stream; unit_* drive the core, unit_c/unit_eoc come back from it.
module rsa_job_ctrl
  import rsa_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int CYCLE_LIMIT = 4096,
  parameter int CLR_CYCLES = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_p,
  input  logic [WIDTH-1:0] in_e,
  input  logic [WIDTH-1:0] in_m,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_c,
  output logic             out_err,
  output logic             unit_en,
  output logic             unit_rstb,
  output logic [WIDTH-1:0] unit_p,
  output logic [WIDTH-1:0] unit_e,
  output logic [WIDTH-1:0] unit_m,
  output logic [WIDTH-1:0] unit_const,
  input  logic [WIDTH-1:0] unit_c,
  input  logic             unit_eoc
);
  localparam int CW = $clog2((CYCLE_LIMIT > CLR_CYCLES ? CYCLE_LIMIT : CLR_CYCLES) + 1);
  state_e           state_q, state_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [WIDTH-1:0] p_q, p_d, e_q, e_d, m_q, m_d, k_q, k_d, c_q, c_d;
  logic             err_q, err_d;
  logic             bad_m, cg_start, cg_done;
  logic [WIDTH-1:0] cg_value;
  // Montgomery setup needs an odd modulus of at least 3
  assign bad_m = ~in_m[0] || in_m < WIDTH'(3);
  assign cg_start = state_q == IDLE && in_valid && !bad_m;
  rsa_const_gen #(.WIDTH(WIDTH)) u_const_gen (
    .clk  (clk),
    .rst  (rst),
    .start(cg_start),
    .m    (m_q),
    .done (cg_done),
    .value(cg_value)
  );
  // cnt_q is shared: CLEAR hold counter, then RUN timeout counter
  always_comb begin
    state_d = state_q;
    cnt_d = cnt_q;
    p_d = p_q;
    e_d = e_q;
    m_d = m_q;
    k_d = k_q;
    c_d = c_q;
    err_d = err_q;
    unique case (state_q)
      IDLE: if (in_valid) begin
        p_d = in_p;
        e_d = in_e;
        m_d = in_m;
        c_d = '0;
        err_d = bad_m;
        state_d = bad_m ? RESP : CONST;
      end
      CONST: if (cg_done) begin
        k_d = cg_value;
        cnt_d = '0;
        state_d = CLEAR;
      end
      CLEAR: begin
        cnt_d = cnt_q == CW'(CLR_CYCLES - 1) ? '0 : cnt_q + CW'(1);
        state_d = cnt_q == CW'(CLR_CYCLES - 1) ? RUN : CLEAR;
      end
      RUN: begin
        cnt_d = cnt_q + CW'(1);
        if (unit_eoc) state_d = CAPTURE;
        else if (cnt_q == CW'(CYCLE_LIMIT - 1)) begin
          c_d = '0;
          err_d = 1'b1;
          state_d = RESP;
        end
      end
      CAPTURE: begin
        c_d = unit_c;
        err_d = 1'b0;
        state_d = RESP;
      end
      RESP: state_d = out_ready ? IDLE : RESP;
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q <= '0;
      p_q <= '0;
      e_q <= '0;
      m_q <= '0;
      k_q <= '0;
      c_q <= '0;
      err_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q <= cnt_d;
      p_q <= p_d;
      e_q <= e_d;
      m_q <= m_d;
      k_q <= k_d;
      c_q <= c_d;
      err_q <= err_d;
    end
  end
  assign in_ready = state_q == IDLE;
  assign out_valid = state_q == RESP;
  assign unit_en = state_q == RUN;
  assign unit_rstb = state_q == RUN;
  assign out_c = c_q;
  assign out_err = err_q;
  assign unit_p = p_q;
  assign unit_e = e_q;
  assign unit_m = m_q;
  assign unit_const = k_q;
endmodule
